// File: rtl/rr_mux_arbiter_if.sv
// Bundle for the rr_mux_arbiter: two req/gnt producer channels, the shared mux
// select, and the registered valid/ready output toward the single consumer.
//   req0/in0/gnt0 : requester 0 handshake and data
//   req1/in1/gnt1 : requester 1 handshake and data
//   sel           : shared mux select (0 = in0, 1 = in1)
//   mux_out       : registered output word, out_valid/out_ready handshake
//   last_sel      : requester granted most recently
//   xfer_cnt      : completed downstream transfers (wraps)
// Modports: master = producers/consumer side, slave = arbiter side.
interface rr_mux_arbiter_if #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 req0;
  logic [WIDTH-1:0]     in0;
  logic                 gnt0;
  logic                 req1;
  logic [WIDTH-1:0]     in1;
  logic                 gnt1;
  logic                 sel;
  logic [WIDTH-1:0]     mux_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 last_sel;
  logic [CNT_WIDTH-1:0] xfer_cnt;

  modport master (
    output req0, in0, req1, in1, out_ready,
    input  gnt0, gnt1, sel, mux_out, out_valid, last_sel, xfer_cnt
  );

  modport slave (
    input  req0, in0, req1, in1, out_ready,
    output gnt0, gnt1, sel, mux_out, out_valid, last_sel, xfer_cnt
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared WIDTH-bit 2:1 mux and a
// one-word output register with a valid/ready handshake downstream.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_mux_arbiter_if.slave (requests, grants, select, output word,
//           last_sel and transfer counter)
// A new word may be loaded in the same cycle the held word is accepted, so
// the output sustains one word per cycle.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StFull} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mux_q, mux_d;
  logic                 last_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic slot_free;
  logic grant;
  logic pick;
  logic accept;

  // Arbitration; pick defaults to last_q so sel holds it when nothing is granted.
  always_comb begin
    slot_free = (state_q == StIdle) || bus.out_ready;
    grant     = 1'b0;
    pick      = last_q;
    if (rst_n && slot_free) begin
      if (bus.req0 && bus.req1) begin
        grant = 1'b1;
        pick  = ~last_q;
      end else if (bus.req0) begin
        grant = 1'b1;
        pick  = 1'b0;
      end else if (bus.req1) begin
        grant = 1'b1;
        pick  = 1'b1;
      end
    end
  end

  // Shared 2:1 datapath mux.
  always_comb begin
    mux_d = bus.sel ? bus.in1 : bus.in0;
  end

  assign accept = (state_q == StFull) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant) state_d = StFull;
      StFull: begin
        if (grant) begin
          state_d = StFull;
        end else if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mux_q   <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        mux_q  <= mux_d;
        last_q <= pick;
      end
      if (accept) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.gnt0      = grant && !pick;
  assign bus.gnt1      = grant && pick;
  assign bus.sel       = rst_n ? pick : 1'b0;
  assign bus.mux_out   = mux_q;
  assign bus.out_valid = (state_q == StFull);
  assign bus.last_sel  = last_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: the driver predicts grants from the
// arbitration rules and queues every granted word; an independent monitor
// pops and compares each word as the consumer accepts it.
module tb_rr_mux_arbiter;

  localparam int unsigned W  = 5;
  localparam int unsigned CW = 8;

  logic clk;
  logic rst_n;

  rr_mux_arbiter_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  rr_mux_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: slot occupancy, last winner, word held in the register.
  bit           m_full;
  bit           m_last;
  logic [W-1:0] m_word;
  logic [W-1:0] exp_q[$];
  int           mon_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_last  = 1'b1;
    m_word  = '0;
    exp_q.delete();
    mon_cnt = 0;
  endtask

  // One clock of stimulus; returns the grants the rules demand this cycle.
  task automatic step(input bit r0, input logic [W-1:0] d0, input bit r1,
                      input logic [W-1:0] d1, input bit rdy, output bit g0, output bit g1);
    bit free, grant, pick;
    @(negedge clk);
    bus.req0      = r0;
    bus.in0       = d0;
    bus.req1      = r1;
    bus.in1       = d1;
    bus.out_ready = rdy;
    #1;
    free  = !m_full || rdy;
    grant = free && (r0 || r1);
    pick  = (r0 && r1) ? !m_last : r1;
    g0    = grant && !pick;
    g1    = grant && pick;
    chk("gnt0", int'(bus.gnt0), int'(g0));
    chk("gnt1", int'(bus.gnt1), int'(g1));
    chk("sel", int'(bus.sel), int'(grant ? pick : m_last));
    chk("out_valid", int'(bus.out_valid), int'(m_full));
    chk("mux_out", int'(bus.mux_out), int'(m_word));
    chk("last_sel", int'(bus.last_sel), int'(m_last));
    if (grant) begin
      m_word = pick ? d1 : d0;
      exp_q.push_back(m_word);
      m_full = 1'b1;
      m_last = pick;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: a word leaves on any edge where valid && ready.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        chk("word_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("accept_word", int'(bus.mux_out), int'(e));
        end
        chk("xfer_cnt", int'(bus.xfer_cnt), mon_cnt % (1 << CW));
        mon_cnt++;
      end
    end
  end

  initial begin
    bit g0, g1;
    bit p0, p1;
    logic [W-1:0] d0, d1;

    model_reset();
    rst_n         = 1'b0;
    bus.req0      = 1'b1;
    bus.in0       = 5'h0A;
    bus.req1      = 1'b1;
    bus.in1       = 5'h15;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mux_out", int'(bus.mux_out), 0);
    chk("rst_last_sel", int'(bus.last_sel), 1);
    chk("rst_xfer_cnt", int'(bus.xfer_cnt), 0);
    chk("rst_gnt0", int'(bus.gnt0), 0);
    chk("rst_gnt1", int'(bus.gnt1), 0);
    chk("rst_sel", int'(bus.sel), 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, then drain.
    step(1'b1, 5'h15, 1'b0, 5'h00, 1'b1, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);

    // Both held: strict alternation.
    repeat (4) step(1'b1, 5'h0A, 1'b1, 5'h15, 1'b1, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);

    // Capture from in1, stall three cycles with req0 waiting, then release.
    step(1'b0, 5'h00, 1'b1, 5'h15, 1'b1, g0, g1);
    repeat (3) step(1'b1, 5'h07, 1'b0, 5'h00, 1'b0, g0, g1);
    step(1'b1, 5'h07, 1'b0, 5'h00, 1'b1, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);

    // Single grant into an empty slot with the consumer stalled.
    step(1'b0, 5'h00, 1'b1, 5'h1C, 1'b0, g0, g1);
    repeat (3) step(1'b0, 5'h00, 1'b1, 5'h03, 1'b0, g0, g1);
    step(1'b0, 5'h00, 1'b1, 5'h03, 1'b1, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);

    // Randomized traffic; requests hold their data until granted, and
    // occasionally withdraw.
    p0 = 1'b0;
    p1 = 1'b0;
    d0 = '0;
    d1 = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1;
        d0 = W'($urandom);
      end else if (p0 && $urandom_range(0, 15) == 0) begin
        p0 = 1'b0;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        d1 = W'($urandom);
      end else if (p1 && $urandom_range(0, 15) == 0) begin
        p1 = 1'b0;
      end
      step(p0, d0, p1, d1, $urandom_range(0, 9) < 7, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    repeat (2) step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);
    chk("drained", exp_q.size(), 0);

    // Asynchronous reset while a word is held.
    step(1'b1, 5'h0A, 1'b0, 5'h00, 1'b0, g0, g1);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0, g0, g1);
    #2;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_mux_out", int'(bus.mux_out), 0);
    chk("arst_gnt0", int'(bus.gnt0), 0);
    chk("arst_gnt1", int'(bus.gnt1), 0);
    chk("arst_sel", int'(bus.sel), 0);
    chk("arst_last_sel", int'(bus.last_sel), 1);
    chk("arst_xfer_cnt", int'(bus.xfer_cnt), 0);
    model_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 5'h03, 1'b1, 5'h1C, 1'b1, g0, g1);
    chk("post_rst_first_gnt0", int'(g0), 1);
    step(1'b1, 5'h03, 1'b1, 5'h1C, 1'b1, g0, g1);
    repeat (3) step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, g0, g1);
    chk("final_xfer_cnt", int'(bus.xfer_cnt), mon_cnt % (1 << CW));
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Two-requester round-robin arbiter that owns the shared WIDTH-bit 2:1 mux and sequences it.
- Each requester presents data with a req/gnt handshake.
- The arbiter selects one requester per transfer, drives the mux select, and captures the selected word into an output register.
- The output register presents the word downstream on a valid/ready handshake.
- Sits between the two producer blocks and the single consumer sharing the datapath.

Parameters:
- WIDTH, 5, data width of in0/in1/mux_out.
- CNT_WIDTH, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 has a word on in0; held with in0 stable until gnt0 sampled high.
- in0  input  WIDTH  requester 0 data.
- req1  input  1  requester 1 has a word on in1; same rules as req0.
- in1  input  WIDTH  requester 1 data.
- gnt0  output  1  combinational; high in a cycle where in0 is captured at the next rising edge.
- gnt1  output  1  combinational; high in a cycle where in1 is captured at the next rising edge.
- sel  output  1  mux select driven to the shared mux; 0 = in0, 1 = in1.
- mux_out  output  WIDTH  registered output word.
- out_valid  output  1  mux_out holds a word not yet accepted.
- out_ready  input  1  consumer accepts mux_out when out_valid && out_ready at a rising edge.
- last_sel  output  1  requester granted most recently.
- xfer_cnt  output  CNT_WIDTH  count of completed downstream transfers.

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values (asserted immediately, independent of clk): out_valid=0, mux_out=0, last_sel=1, xfer_cnt=0.
- During reset: gnt0=gnt1=0, sel=0.
- States: IDLE (out_valid=0) and FULL (out_valid=1).
- Slot free: slot_free = !out_valid || out_ready.
- Arbitration (combinational, only when slot_free && rst_n):
  - Only req0 -> pick 0.
  - Only req1 -> pick 1.
  - Both -> pick !last_sel (round-robin).
  - Neither -> no grant.
- Grant outputs: gntN = slot_free && pick==N. At most one grant high per cycle.
- sel follows the pick when a grant is issued; otherwise sel holds last_sel.
- On a rising edge with a grant:
  - mux_out <= selected input.
  - out_valid <= 1.
  - last_sel <= pick.
- IDLE -> FULL on any grant. IDLE with no req stays IDLE.
- FULL, out_ready=0: hold. mux_out, out_valid and last_sel are unchanged and no grants are issued; requesters stall.
- FULL, out_ready=1, grant issued: back-to-back. The new word is loaded at the same edge the old word is accepted, and the state stays FULL. This gives full throughput of one word per cycle.
- FULL, out_ready=1, no request: FULL -> IDLE. out_valid <= 0 and mux_out holds its last value.
- Latency: data captured at the gnt edge is visible on mux_out one cycle later.
- xfer_cnt increments by 1 on every edge with out_valid && out_ready. It wraps modulo 2^CNT_WIDTH, with no saturation.
- Fairness: with both requests held continuously and out_ready=1, grants strictly alternate 0,1,0,1...
- A request dropped before its grant is legal; it is simply not served.
- out_ready while out_valid=0 has no effect and does not count a transfer.
- Reset mid-operation: a pending word is discarded (out_valid=0 immediately) and arbitration restarts favouring requester 0.

Test Plan:
- Reset, then req0=1, in0=5'h15, req1=0, out_ready=1 -> gnt0=1 that cycle; next cycle mux_out=5'h15, out_valid=1, last_sel=0; xfer_cnt=1 one cycle later.
- From reset, req0=req1=1 with in0=5'h0A, in1=5'h15, out_ready=1 for 4 cycles -> grants 0,1,0,1; mux_out sequence 0A,15,0A,15; xfer_cnt=4 after last accept.
- Capture 5'h15 from in1, then out_ready=0 for 3 cycles with req0=1 -> gnt0=0 throughout; mux_out stays 5'h15; out_valid=1; xfer_cnt unchanged. Raise out_ready -> gnt0=1 the same cycle and back-to-back load.
- CNT_WIDTH=2, five accepted transfers -> xfer_cnt sequence 1,2,3,0,1.
- Drive rst_n low mid-cycle while out_valid=1, mux_out=5'h0A -> out_valid=0, mux_out=0, gnt0=gnt1=0 before the next clk edge. After release with both req high -> requester 0 is granted first.
- Single requester with out_ready=0 while out_valid=0 -> gnt granted once. After that, no second grant until accepted; mux_out never overwritten while out_valid && !out_ready.
